// File: rtl/lsu_byte_sequencer.sv
// MEM-stage load/store sequencer: splits byte/half/word requests into single-byte accesses
// on an 8-bit data memory, little-endian, and assembles/extends load results.
module lsu_byte_sequencer #(
   parameter int unsigned NBYTES_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   localparam int unsigned CW = (NBYTES_MAX > 1) ? $clog2(NBYTES_MAX) : 1;
   localparam int unsigned DW = 8 * NBYTES_MAX;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [7:0]      addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   ld_q, ld_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [CW-1:0]   last_cnt;
   logic [CW+2:0]   lane_bit;
   logic            req_bad;
   logic [31:0]     ld_word;

   assign lane_bit = {cnt_q, 3'b000};
   assign req_bad  = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   always_comb begin
      case (size_q)
         2'b00:   last_cnt = '0;
         2'b01:   last_cnt = CW'(1);
         default: last_cnt = CW'(NBYTES_MAX - 1);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      ld_word = '0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = DW'(req_wdata);
               cnt_d   = '0;
               ld_d    = '0;
               err_d   = req_bad;
               if (req_bad) begin
                  rdata_d = '0;
                  state_d = StResp;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            if (!write_q) begin
               ld_d[lane_bit +: 8] = mem_rdata;
            end
            if (cnt_q == last_cnt) begin
               state_d = StResp;
               // Result is registered here so it stays stable after the response pulse.
               ld_word = 32'(ld_d);
               if (write_q) begin
                  rdata_d = '0;
               end else begin
                  case (size_q)
                     2'b00:   rdata_d = {{24{~uns_q & ld_word[7]}}, ld_word[7:0]};
                     2'b01:   rdata_d = {{16{~uns_q & ld_word[15]}}, ld_word[15:0]};
                     default: rdata_d = ld_word;
                  endcase
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory strobes come from registered state only.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == StAccess) begin
         mem_we   = write_q;
         mem_addr = addr_q + 8'(cnt_q);
         if (write_q) begin
            mem_wdata = wdata_q[lane_bit +: 8];
         end
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_err   = (state_q == StResp) && err_q;
   assign resp_rdata = rdata_q;

endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer in the MEM stage of the pipelined RISC-V core, acting as the initiator for the 8-bit-wide, 256-entry data memory. It accepts one 32-bit byte/half/word load or store from the pipeline and splits it into 1, 2 or 4 single-byte memory accesses on consecutive cycles, little-endian. It assembles and sign/zero-extends load data, flags misaligned or illegal requests, and holds `req_ready` low while busy so the hazard unit can stall the pipeline.

## Interface
- `NBYTES_MAX`, 4: maximum bytes per request; sizes the byte counter and the data registers.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  8  byte address.
- `req_wdata`  in  32  store data; byte 0 is `[7:0]`.
- `resp_valid`  out  1  one-cycle pulse when the request completes.
- `resp_err`  out  1  qualified by `resp_valid`; set for misaligned or illegal requests.
- `resp_rdata`  out  32  load result; holds its value until the next response.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  8  memory byte address.
- `mem_wdata`  out  8  memory write byte.
- `mem_rdata`  in  8  memory read byte, combinational from `mem_addr` in the same cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1.
  - A handshake occurs when `req_valid` and `req_ready` are both high at the clock edge.
  - On handshake, latch write, size, unsigned, addr and wdata; clear the byte counter `cnt` to 0.
  - Request is an error if `req_size` = 11, or size = half and `addr[0]` = 1, or size = word and `addr[1:0]` ≠ 00.
  - Error request: go to RESP with `resp_err` = 1; no memory access is made.
  - Legal request: go to ACCESS; `n` = 1/2/4 for byte/half/word.
- **ACCESS**
  - `mem_addr` = latched addr + `cnt`.
  - Store:
    - `mem_we` = 1.
    - `mem_wdata` = latched `wdata[8*cnt +: 8]`.
  - Load:
    - `mem_we` = 0.
    - Capture `mem_rdata` into byte lane `cnt` of the load register at the clock edge.
  - When `cnt` = `n`−1, go to RESP; otherwise increment `cnt`.
  - Alignment guarantees that addr + `cnt` never wraps past 0xFF.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - `resp_err` = 1 only for error requests.
  - `resp_rdata` for a load:
    - byte: extend from bit 7.
    - half: extend from bit 15.
    - word: pass through unmodified.
    - Sign- or zero-extend according to latched `req_unsigned`.
  - `resp_rdata` for a store or an error: 0x00000000.
- `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only; there is no combinational path from `req_*` to `mem_*`.
- When `mem_we` is low, `mem_wdata` = 0 and `mem_addr` = 0, except during load ACCESS, where `mem_addr` follows the rule above.
- `req_valid` is ignored outside IDLE.
- A request held valid across a response is taken on the first IDLE cycle after RESP.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_err` = 0.
  - `resp_rdata` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Counter and latched request registers = 0.
- Handshake at edge T0:
  - ACCESS occupies cycles T0+1 … T0+`n`.
  - `resp_valid` is high in cycle T0+`n`+1.
  - `req_ready` is high again in cycle T0+`n`+2.
- Byte latency: 2 cycles. Half: 3 cycles. Word: 5 cycles.
- Error request: `resp_valid` in cycle T0+1; `req_ready` high in T0+2.
- Maximum throughput: one request per `n`+2 cycles.
- Reset asserted mid-request:
  - Immediate return to IDLE with all outputs at reset values.
  - A partially written store is not completed or rolled back.
  - No `resp_valid` is produced for the aborted request.

## Test plan
- Word store 0xDEADBEEF to 0x10:
  - `mem_we` high for exactly 4 cycles with addr/wdata 10/EF, 11/BE, 12/AD, 13/DE.
  - Then `resp_valid` = 1, `resp_err` = 0, `resp_rdata` = 0.
- Byte loads from 0x13 after the store above:
  - Signed → `resp_rdata` = 0xFFFFFFDE, 2 cycles after the handshake.
  - Unsigned → 0x000000DE.
- Half loads:
  - Signed from 0x12 → 0xFFFFDEAD.
  - Unsigned from 0x10 → 0x0000BEEF.
  - Word load from 0x10 → 0xDEADBEEF, 5 cycles after the handshake.
- Error requests:
  - Word store to 0x11, half load from 0x13, and `req_size` = 11 each give `resp_valid` with `resp_err` = 1 one cycle after the handshake.
  - `mem_we` never rises; memory contents are unchanged.
- Reset mid-request:
  - Word store 0x11223344 to 0x20; drop `rst` after 2 ACCESS cycles.
  - All outputs return to 0, `req_ready` returns to 1, and no `resp_valid` is produced.
  - Bytes 0x20 = 44 and 0x21 = 33 were driven; 0x22 and 0x23 were never written.
- Back-to-back requests with `req_valid` held high:
  - `req_ready` is low throughout each operation.
  - Exactly one `resp_valid` per request, spaced `n`+2 cycles apart.
